// File: rtl/arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner encoding,
// strobe width and the winner-selection helper.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_e;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_e;

  localparam int STRB_W = 4;

  // Data wins by default; under contention, alternate away from the last grant.
  function automatic arb_owner_e arb_pick(logic if_p, logic d_p, arb_owner_e last);
    if (if_p && d_p) return (last == OWN_D) ? OWN_IF : OWN_D;
    return d_p ? OWN_D : OWN_IF;
  endfunction
endpackage

// File: rtl/arb_timeout_cnt.sv
// WAIT-state watchdog: cleared when a command is accepted, counts cycles
// without a memory response, flags the last allowed cycle.
module arb_timeout_cnt #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CW'(1);
  end

  assign expired = (cnt == LAST);
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and load/store,
// one outstanding transaction at a time. Optional WAIT timeout: ARB_TIMEOUT_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              core_stall
);
  arb_state_e state;
  arb_owner_e owner, last_owner, win;
  logic rsp_ok, tmo, done, if_done, d_done, if_pend, d_pend, load;

`ifdef ARB_TIMEOUT_EN
  logic tmo_exp;
  arb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == REQ && m_gnt),
    .en      (state == WAIT && !m_rvalid),
    .expired (tmo_exp)
  );
  assign tmo = (state == WAIT) && !m_rvalid && tmo_exp;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  // The completing owner still holds its req this cycle, so it is masked out.
  always_comb begin
    rsp_ok  = (state == WAIT) && m_rvalid;
    done    = rsp_ok || tmo;
    if_done = done && (owner == OWN_IF);
    d_done  = done && (owner == OWN_D);
    if_pend = if_req && !if_done;
    d_pend  = d_req && !d_done;
    win     = arb_pick(if_pend, d_pend, last_owner);
    load    = (if_pend || d_pend) && ((state == IDLE) || rsp_ok);
  end

  assign if_rvalid  = if_done;
  assign d_rvalid   = d_done;
  assign if_rdata   = (if_done && rsp_ok) ? m_rdata : '0;
  assign d_rdata    = (d_done && rsp_ok) ? m_rdata : '0;
  assign if_err     = if_done && tmo;
  assign d_err      = d_done && tmo;
  assign core_stall = (if_req && !if_rvalid) || (d_req && !d_rvalid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
    end else if (load) begin
      state      <= REQ;
      m_req      <= 1'b1;
      owner      <= win;
      last_owner <= win;
      m_we       <= (win == OWN_D) && d_we;
      m_addr     <= (win == OWN_D) ? d_addr : if_addr;
      m_wdata    <= (win == OWN_D) ? d_wdata : '0;
      m_wstrb    <= ((win == OWN_D) && d_we) ? d_wstrb : '0;
    end else if (state == REQ && m_gnt) begin
      state <= WAIT;
      m_req <= 1'b0;
    end else if (done) begin
      state <= IDLE;
    end
  end
endmodule
